// File: rtl/smc_bus_bridge.sv
// SMC bus front end: synchronises the async SMC strobes and turns each access into a one-cycle
// internal request. Optional read timeout is enabled by defining SMC_BRIDGE_TIMEOUT_EN.
module smc_bus_bridge #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 25,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(16'hDEAD)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  cs_n_i,
    input  logic                  rd_n_i,
    input  logic                  wr_n_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  oe_o,
    output logic                  req_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    input  logic                  rvalid_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  busy_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StRdReq,
        StRdWait,
        StRdDrive,
        StRelease
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0]              cs_sync_q, rd_sync_q, wr_sync_q;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    err_q, err_d;
`ifdef SMC_BRIDGE_TIMEOUT_EN
    logic [15:0]             cnt_q, cnt_d;
`endif

    logic cs_act2, rd_act2, wr_act2;
    logic cs_act3, rd_act3, wr_act3;
    logic start, rd_release, any_release;

    // Bit 0 is s1, bit 1 is s2, bit 2 is s3; idle level is 1.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cs_sync_q <= 3'b111;
            rd_sync_q <= 3'b111;
            wr_sync_q <= 3'b111;
        end else begin
            cs_sync_q <= {cs_sync_q[1:0], cs_n_i};
            rd_sync_q <= {rd_sync_q[1:0], rd_n_i};
            wr_sync_q <= {wr_sync_q[1:0], wr_n_i};
        end
    end

    always_comb begin
        cs_act2     = !cs_sync_q[1];
        rd_act2     = !rd_sync_q[1];
        wr_act2     = !wr_sync_q[1];
        cs_act3     = !cs_sync_q[2];
        rd_act3     = !rd_sync_q[2];
        wr_act3     = !wr_sync_q[2];
        start       = cs_act2 && (rd_act2 || wr_act2) && !(cs_act3 && (rd_act3 || wr_act3));
        rd_release  = !cs_act2 || !rd_act2;
        // After a write or a strobe collision, wait until every strobe is gone.
        any_release = !cs_act2 || (!rd_act2 && !wr_act2);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef SMC_BRIDGE_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef SMC_BRIDGE_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        err_d   = 1'b0;
`ifdef SMC_BRIDGE_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (rd_act2 && wr_act2) begin
                        err_d   = 1'b1;
                        state_d = StRelease;
                    end else if (wr_act2) begin
                        addr_d  = addr_i;
                        wdata_d = data_i;
                        state_d = StWrReq;
                    end else begin
                        addr_d  = addr_i;
                        state_d = StRdReq;
                    end
                end
            end
            StWrReq: state_d = StRelease;
            StRdReq: begin
                state_d = StRdWait;
`ifdef SMC_BRIDGE_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            StRdWait: begin
                // A host that has already let go gets nothing driven back.
                if (rd_release) begin
                    state_d = StIdle;
                end else if (rvalid_i) begin
                    data_d  = rdata_i;
                    state_d = StRdDrive;
`ifdef SMC_BRIDGE_TIMEOUT_EN
                end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    data_d  = TIMEOUT_DATA;
                    err_d   = 1'b1;
                    state_d = StRdDrive;
                end else begin
                    cnt_d = cnt_q + 16'd1;
`endif
                end
            end
            StRdDrive: begin
                if (rd_release) state_d = StIdle;
            end
            StRelease: begin
                if (any_release) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_o   = (state_q == StWrReq) || (state_q == StRdReq);
    assign we_o    = (state_q == StWrReq);
    assign oe_o    = (state_q == StRdDrive);
    assign busy_o  = (state_q != StIdle);
    assign err_o   = err_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign data_o  = data_q;

endmodule

// File: tb/tb_smc_bus_bridge.sv
// Scoreboard bench for smc_bus_bridge: stimulus pushes expected req/err/drive events, a
// negedge monitor pops and compares them. Covers both SMC_BRIDGE_TIMEOUT_EN builds.
module tb_smc_bus_bridge;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 25;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          cs_n_i, rd_n_i, wr_n_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] data_i;
    logic [DW-1:0] data_o;
    logic          oe_o, req_o, we_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] wdata_o;
    logic          rvalid_i;
    logic [DW-1:0] rdata_i;
    logic          busy_o, err_o;

    always #5 clk = ~clk;

    smc_bus_bridge #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(8),
        .TIMEOUT_DATA  (16'hDEAD)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .cs_n_i  (cs_n_i),
        .rd_n_i  (rd_n_i),
        .wr_n_i  (wr_n_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .oe_o    (oe_o),
        .req_o   (req_o),
        .we_o    (we_o),
        .addr_o  (addr_o),
        .wdata_o (wdata_o),
        .rvalid_i(rvalid_i),
        .rdata_i (rdata_i),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    typedef enum int {EvReq, EvErr, EvDrv} ev_kind_e;
    typedef struct {
        ev_kind_e      kind;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  req_cnt = 0;
    int  err_cnt = 0;
    int  oe_cnt = 0;

    logic          resp_en = 1'b0;
    int            resp_delay = 3;
    logic [DW-1:0] resp_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input ev_kind_e k, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        ev_t e;
        e.kind = k;
        e.we   = we;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic bus_start(input logic rd, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
        @(negedge clk);
        addr_i = a;
        data_i = d;
        cs_n_i = 1'b0;
        rd_n_i = !rd;
        wr_n_i = !wr;
    endtask

    task automatic bus_end();
        @(negedge clk);
        cs_n_i = 1'b1;
        rd_n_i = 1'b1;
        wr_n_i = 1'b1;
    endtask

    // Counts negedges until req_o, expected 3 (E2) after the strobe is driven.
    task automatic wait_req(input string name);
        int n = 0;
        while (!req_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n), 32'd3);
    endtask

    task automatic wait_oe(input string name, input int exp_cycles);
        int m = 0;
        while (!oe_o && m < 40) begin
            @(negedge clk);
            m++;
        end
        check(name, 32'(m), 32'(exp_cycles));
    endtask

    // Monitor / scoreboard
    initial begin
        ev_t  e;
        logic oe_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (req_o) begin
                req_cnt++;
                check("req_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("req_kind", 32'(e.kind), 32'(EvReq));
                    check("req_we", 32'(we_o), 32'(e.we));
                    check("req_addr", 32'(addr_o), 32'(e.addr));
                    if (e.we) check("req_wdata", 32'(wdata_o), 32'(e.data));
                end
            end
            if (err_o) begin
                err_cnt++;
                check("err_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("err_kind", 32'(e.kind), 32'(EvErr));
                end
            end
            if (oe_o && !oe_prev) begin
                oe_cnt++;
                check("drv_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("drv_kind", 32'(e.kind), 32'(EvDrv));
                    check("drv_data", 32'(data_o), 32'(e.data));
                end
            end
            oe_prev = oe_o;
        end
    end

    // Internal read responder
    initial begin
        rvalid_i = 1'b0;
        rdata_i  = '0;
        forever begin
            @(negedge clk);
            if (req_o && !we_o && resp_en) begin
                repeat (resp_delay) @(negedge clk);
                rvalid_i = 1'b1;
                rdata_i  = resp_data;
                @(negedge clk);
                rvalid_i = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0, e0, o0;
        logic [DW-1:0] last_rd;
        reset_i = 1'b1;
        cs_n_i  = 1'b1;
        rd_n_i  = 1'b1;
        wr_n_i  = 1'b1;
        addr_i  = '0;
        data_i  = '0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_oe", 32'(oe_o), 32'd0);
        check("rst_req", 32'(req_o), 32'd0);
        check("rst_we", 32'(we_o), 32'd0);
        check("rst_addr", 32'(addr_o), 32'd0);
        check("rst_wdata", 32'(wdata_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);

        // Write
        r0 = req_cnt; o0 = oe_cnt;
        push(EvReq, 1'b1, 25'h2004, 16'hA5A5);
        bus_start(1'b0, 1'b1, 25'h2004, 16'hA5A5);
        wait_req("wr_latency");
        addr_i = '0;
        data_i = '0;
        repeat (5) @(negedge clk);
        bus_end();
        repeat (4) @(negedge clk);
        check("wr_req_count", 32'(req_cnt - r0), 32'd1);
        check("wr_no_oe", 32'(oe_cnt - o0), 32'd0);
        check("wr_busy_after", 32'(busy_o), 32'd0);
        check("wr_addr_held", 32'(addr_o), 32'h2004);
        check("wr_wdata_held", 32'(wdata_o), 32'hA5A5);

        // Read with rvalid 3 cycles after req
        resp_en = 1'b1; resp_delay = 3; resp_data = 16'h1234;
        push(EvReq, 1'b0, 25'h0010, 16'h0);
        push(EvDrv, 1'b0, 25'h0010, 16'h1234);
        bus_start(1'b1, 1'b0, 25'h0010, 16'h0);
        wait_req("rd_latency");
        wait_oe("rd_turnaround", 4);
        repeat (3) @(negedge clk);
        check("rd_data", 32'(data_o), 32'h1234);
        bus_end();
        @(negedge clk);
        check("rd_oe_after_f0", 32'(oe_o), 32'd1);
        @(negedge clk);
        check("rd_oe_after_f1", 32'(oe_o), 32'd1);
        @(negedge clk);
        check("rd_oe_after_f2", 32'(oe_o), 32'd0);
        check("rd_busy_after", 32'(busy_o), 32'd0);
        repeat (3) @(negedge clk);

        // Read with no responder
        resp_en = 1'b0;
        e0 = err_cnt; o0 = oe_cnt;
        push(EvReq, 1'b0, 25'h0020, 16'h0);
`ifdef SMC_BRIDGE_TIMEOUT_EN
        push(EvErr, 1'b0, 25'h0020, 16'h0);
        push(EvDrv, 1'b0, 25'h0020, 16'hDEAD);
        bus_start(1'b1, 1'b0, 25'h0020, 16'h0);
        wait_req("to_latency");
        wait_oe("to_turnaround", 9);
        repeat (3) @(negedge clk);
        check("to_data", 32'(data_o), 32'hDEAD);
        bus_end();
        repeat (4) @(negedge clk);
        check("to_err_count", 32'(err_cnt - e0), 32'd1);
        check("to_oe_count", 32'(oe_cnt - o0), 32'd1);
        last_rd = 16'hDEAD;
`else
        bus_start(1'b1, 1'b0, 25'h0020, 16'h0);
        wait_req("to_latency");
        repeat (20) @(negedge clk);
        check("to_still_busy", 32'(busy_o), 32'd1);
        check("to_no_oe", 32'(oe_cnt - o0), 32'd0);
        bus_end();
        repeat (4) @(negedge clk);
        check("to_no_err", 32'(err_cnt - e0), 32'd0);
        last_rd = 16'h1234;
`endif
        check("to_busy_after", 32'(busy_o), 32'd0);

        // Simultaneous read and write strobes
        r0 = req_cnt; o0 = oe_cnt; e0 = err_cnt;
        push(EvErr, 1'b0, 25'h0, 16'h0);
        bus_start(1'b1, 1'b1, 25'h0030, 16'h0);
        repeat (8) @(negedge clk);
        bus_end();
        repeat (4) @(negedge clk);
        check("both_err_count", 32'(err_cnt - e0), 32'd1);
        check("both_no_req", 32'(req_cnt - r0), 32'd0);
        check("both_no_oe", 32'(oe_cnt - o0), 32'd0);
        check("both_busy_after", 32'(busy_o), 32'd0);

        // Abort: release in RD_WAIT, late rvalid
        resp_en = 1'b1; resp_delay = 12; resp_data = 16'h5555;
        o0 = oe_cnt;
        push(EvReq, 1'b0, 25'h0040, 16'h0);
        bus_start(1'b1, 1'b0, 25'h0040, 16'h0);
        wait_req("ab_latency");
        repeat (2) @(negedge clk);
        bus_end();
        repeat (16) @(negedge clk);
        check("ab_no_oe", 32'(oe_cnt - o0), 32'd0);
        check("ab_busy", 32'(busy_o), 32'd0);
        check("ab_data_kept", 32'(data_o), 32'(last_rd));

        // Reset during RD_DRIVE
        resp_delay = 1; resp_data = 16'h7777;
        push(EvReq, 1'b0, 25'h0050, 16'h0);
        push(EvDrv, 1'b0, 25'h0050, 16'h7777);
        bus_start(1'b1, 1'b0, 25'h0050, 16'h0);
        wait_req("rst_rd_latency");
        wait_oe("rst_rd_turnaround", 2);
        reset_i = 1'b1;
        @(negedge clk);
        check("mid_rst_data", 32'(data_o), 32'd0);
        check("mid_rst_oe", 32'(oe_o), 32'd0);
        check("mid_rst_req", 32'(req_o), 32'd0);
        check("mid_rst_we", 32'(we_o), 32'd0);
        check("mid_rst_addr", 32'(addr_o), 32'd0);
        check("mid_rst_wdata", 32'(wdata_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_err", 32'(err_o), 32'd0);
        cs_n_i = 1'b1;
        rd_n_i = 1'b1;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        push(EvReq, 1'b1, 25'h0055, 16'hBEEF);
        bus_start(1'b0, 1'b1, 25'h0055, 16'hBEEF);
        wait_req("post_rst_latency");
        repeat (4) @(negedge clk);
        bus_end();
        repeat (4) @(negedge clk);
        check("post_rst_busy", 32'(busy_o), 32'd0);
        check("post_rst_addr", 32'(addr_o), 32'h0055);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
